ccmul_conj_serial: RTL
======================

# ccmul_conj_serial

Serial conjugate complex multiplier: computes (x + jy)·(c − js), the de-rotation counterpart of the three-multiplier twiddle rotator, using one time-shared W1×W signed multiplier. Sits on the inverse-transform / de-rotation path. It takes the same precomputed twiddle triple (c, c+s, c−s) as the forward rotator and returns scaled real/imag results through a start/done handshake. Throughput is one operation per 5 cycles.

## Interface
- W2, 17, product/accumulator width (W1 + W)
- W1, 9, width of x+y and of the c±s inputs
- W, 8, input/output data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- x_in, y_in, c_in  in  W signed  operand real/imag, cos
- cps_in, cms_in  in  W1 signed  cos+sin, cos−sin
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse: r_out/i_out updated
- r_out, i_out  out  W signed  scaled result, held until next done

## Operation
- Identity: P1 = (x+y)·c, P2 = (c−s)·y, P3 = (c+s)·x; r = P1 − P2 = xc + ys; i = P1 − P3 = yc − xs.
- Start accepted in IDLE: latch x, y, c, cps, cms; compute xpy = x + y at W1 bits (sign-extended, no overflow possible).
- FSM states IDLE → M1 → M2 → M3 → OUT → IDLE:
  - M1: multiplier ← (xpy, c); p1 register ← product.
  - M2: multiplier ← (cms, y); r_acc ← p1 − product.
  - M3: multiplier ← (cps, x); i_acc ← p1 − product.
  - OUT: r_out ← r_acc[W2−3:W−1], i_out ← i_acc[W2−3:W−1]; done ← 1.
- Multiplier: signed W1×W → W2. Subtractions are W2 wide and wrap modulo 2^W2. There is no saturation, matching the forward rotator.
- Output scaling is truncation (floor), with no rounding.
- start while busy is ignored; latched operands are never overwritten mid-operation.
- Input changes after acceptance have no effect on the current result.

## Timing
- Reset (asynchronous assert, synchronous-safe release) clears the following: state = IDLE, busy = 0, done = 0, r_out = 0, i_out = 0, and all internal registers = 0.
- start high at edge k in IDLE:
  - busy is high after edge k.
  - p1 is loaded at edge k+1, r_acc at k+2, i_acc at k+3.
  - r_out, i_out and done are updated at edge k+4.
  - busy falls and done is high for cycle k+4..k+5.
- Latency from start to done is 4 clocks.
- A new start may be sampled at edge k+5, which is the cycle done is high (state is already IDLE). Back-to-back issue therefore gives done every 5 cycles.
- Reset asserted mid-operation aborts the operation: no done pulse, outputs return to 0, and the next start after release behaves normally.
- done never asserts without a preceding accepted start.

## Structure
- Shared package ccmul_pkg:
  - default W, W1, W2 constants;
  - FSM state enum (IDLE, M1, M2, M3, OUT);
  - scaling slice bounds (W2−3, W−1), shared with the forward rotator.
- One sub-module, cmul_shared_mult: registered-operand-free signed W1×W multiplier with operand muxes selected by state. Subtract/accumulate stays in the top level.

## Test plan
- c=64, s=0 (cps=cms=64), x=100, y=−50, start → after 4 clocks done=1, r_out=50, i_out=−25.
- c=0, s=127 (cps=127, cms=−127), x=64, y=32 → r_out=31, i_out=−64 (checks floor truncation of −63.5).
- c=127, s=0, x=127, y=127 → r_out=126, i_out=126. Then x=−128, y=−128, c=127, cps=cms=127 → r_out=−127, i_out=−127.
- Assert start again on cycles 1–3 while busy, with different inputs → ignored; single done carrying the first operation's result.
- Reset low during M2 → r_out=i_out=0, busy=done=0, no done pulse. After release, run scenario 1 → correct result.
- start held high continuously with a fresh random operand each accept → done every 5 cycles. Every result matches the reference model: floor((xc+ys)/128) and floor((yc−xs)/128), modulo W2 wrap.

Source files
------------

// File: rtl/ccmul_pkg.sv
// ccmul_pkg: constants and types shared by the conjugate complex multiplier.
// The forward twiddle rotator uses the same values.
//
// Contents:
//   W, W1, W2          data width, x+y / c+-s width, product/accumulator width
//   SCALE_HI/SCALE_LO  bits of the accumulator that form the scaled output
//   state_t            sequencing FSM states
//   sext_add           full-precision sum of two W-bit signed values
package ccmul_pkg;

  localparam int W  = 8;
  localparam int W1 = W + 1;
  localparam int W2 = W1 + W;

  // The twiddle factors are Q1.(W-1), so products carry W-1 fraction bits.
  // Taking [W2-3:W-1] divides by 2^(W-1) with floor (plain truncation) and
  // keeps W result bits.
  localparam int SCALE_HI = W2 - 3;
  localparam int SCALE_LO = W - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M1   = 3'd1,
    M2   = 3'd2,
    M3   = 3'd3,
    OUT  = 3'd4
  } state_t;

  // x + y widened by one bit, so the sum can never overflow.
  function automatic logic signed [W1-1:0] sext_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
    logic signed [W1-1:0] ae;
    logic signed [W1-1:0] be;
    ae = {a[W-1], a};
    be = {b[W-1], b};
    return ae + be;
  endfunction

endpackage

// File: rtl/cmul_shared_mult.sv
// cmul_shared_mult: the single signed W1 x W multiplier that the conjugate
// multiplier time-shares across its three products. The operand muxes
// are selected by the sequencing state. The block holds no registers, so
// the product settles within the same cycle and the caller registers it.
//
// Ports:
//   sel      current FSM state (ccmul_pkg::state_t encoding)
//   xpy      latched x+y, W1 bits, used in M1 with c
//   cms      latched c-s, W1 bits, used in M2 with y
//   cps      latched c+s, W1 bits, used in M3 with x
//   c, y, x  latched W-bit operands
//   product  W2-bit signed product; zero in states that use no product
module cmul_shared_mult
  import ccmul_pkg::*;
(
  input  logic [2:0]           sel,
  input  logic signed [W1-1:0] xpy,
  input  logic signed [W1-1:0] cms,
  input  logic signed [W1-1:0] cps,
  input  logic signed [W-1:0]  c,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  x,
  output logic signed [W2-1:0] product
);

  logic signed [W1-1:0] op_a;
  logic signed [W-1:0]  op_b;
  logic signed [W2-1:0] op_a_ext;
  logic signed [W2-1:0] op_b_ext;

  // M1: P1 = (x+y)*c   M2: P2 = (c-s)*y   M3: P3 = (c+s)*x
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_t'(sel))
      M1: begin
        op_a = xpy;
        op_b = c;
      end
      M2: begin
        op_a = cms;
        op_b = y;
      end
      M3: begin
        op_a = cps;
        op_b = x;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  // Both operands are sign-extended to the full product width before the
  // multiply. The low W2 bits of the W2 x W2 product then equal the exact
  // W1 x W signed product, which always fits in W2 bits.
  assign op_a_ext = {{(W2-W1){op_a[W1-1]}}, op_a};
  assign op_b_ext = {{(W2-W){op_b[W-1]}}, op_b};
  assign product  = op_a_ext * op_b_ext;

endmodule

// File: rtl/ccmul_conj_serial.sv
// ccmul_conj_serial: serial conjugate complex multiplier.
// It computes (x + jy)(c - js) with one shared multiplier using three products:
//   P1 = (x+y)c, P2 = (c-s)y, P3 = (c+s)x
//   r  = P1 - P2 = xc + ys,   i = P1 - P3 = yc - xs
// The results are divided by 2^(W-1) with floor truncation. There is no
// rounding and no saturation, so the accumulators wrap modulo 2^W2.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      operation request, sampled only in IDLE
//   x_in,y_in  operand real/imag (W signed)
//   c_in       cos (W signed)
//   cps_in     cos+sin (W1 signed)
//   cms_in     cos-sin (W1 signed)
//   busy       high while an accepted operation is in flight
//   done       one-cycle pulse when r_out/i_out update
//   r_out      scaled real result (W signed), held until the next done
//   i_out      scaled imag result (W signed), held until the next done
//   state_dbg  current FSM state encoding, for observation
//
// Handshake: a start seen at a rising edge in IDLE is accepted, and all
// operands are captured at that same edge. busy is high from the next cycle
// through the OUT cycle. start while busy is ignored. done pulses for one
// cycle 4 clocks after acceptance, and it coincides with IDLE. A start
// sampled during that done cycle is therefore accepted, which gives a
// back-to-back rate of one result every 5 cycles.
module ccmul_conj_serial
  import ccmul_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  input  logic signed [W-1:0]  c_in,
  input  logic signed [W1-1:0] cps_in,
  input  logic signed [W1-1:0] cms_in,
  output logic                 busy,
  output logic                 done,
  output logic signed [W-1:0]  r_out,
  output logic signed [W-1:0]  i_out,
  output logic [2:0]           state_dbg
);

  state_t state_q;
  state_t state_d;

  logic signed [W-1:0]  x_q;
  logic signed [W-1:0]  y_q;
  logic signed [W-1:0]  c_q;
  logic signed [W1-1:0] cps_q;
  logic signed [W1-1:0] cms_q;
  logic signed [W1-1:0] xpy_q;

  logic signed [W2-1:0] p1_q;
  logic signed [W2-1:0] r_acc_q;
  logic signed [W2-1:0] i_acc_q;
  logic signed [W2-1:0] product;

  logic accept;

  assign accept    = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = M1;
      M1:      state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand capture. Operands load only on acceptance, so input changes
  // and repeated starts during an operation cannot disturb it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q   <= '0;
      y_q   <= '0;
      c_q   <= '0;
      cps_q <= '0;
      cms_q <= '0;
      xpy_q <= '0;
    end else if (accept) begin
      x_q   <= x_in;
      y_q   <= y_in;
      c_q   <= c_in;
      cps_q <= cps_in;
      cms_q <= cms_in;
      xpy_q <= sext_add(x_in, y_in);
    end
  end

  // ---------------------------------------------------------------------
  // Shared multiplier
  // ---------------------------------------------------------------------
  cmul_shared_mult u_mult (
    .sel     (state_q),
    .xpy     (xpy_q),
    .cms     (cms_q),
    .cps     (cps_q),
    .c       (c_q),
    .y       (y_q),
    .x       (x_q),
    .product (product)
  );

  // ---------------------------------------------------------------------
  // Accumulate and output. p1 is reused by both subtractions, so it is
  // kept for the whole operation. The W2-bit subtractions wrap on purpose.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_q    <= '0;
      r_acc_q <= '0;
      i_acc_q <= '0;
      r_out   <= '0;
      i_out   <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state_q == OUT);
      case (state_q)
        M1:  p1_q    <= product;
        M2:  r_acc_q <= p1_q - product;
        M3:  i_acc_q <= p1_q - product;
        OUT: begin
          r_out <= r_acc_q[SCALE_HI:SCALE_LO];
          i_out <= i_acc_q[SCALE_HI:SCALE_LO];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
